rvfi_trace_gen: RTL and testbench
=================================

RVFI_TRACE_GEN -- requirements
Module: rvfi_trace_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register/PC width (ILEN fixed at 32).
REQ-002 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn input 1: reset, synchronous, active-low.
REQ-004 SHALL have port commit_valid input 1: core retires one instruction this cycle.
REQ-005 SHALL have port commit_insn input 32: retired instruction word.
REQ-006 SHALL have port commit_pc input XLEN: PC of retired instruction.
REQ-007 SHALL have port commit_next_pc input XLEN: PC of next instruction.
REQ-008 SHALL have ports commit_rs1_addr/commit_rs2_addr input 5 each: source register indices read.
REQ-009 SHALL have ports commit_rs1_data/commit_rs2_data input XLEN each: source operand values.
REQ-010 SHALL have port commit_rd_addr input 5 and commit_rd_data input XLEN: destination index and written value.
REQ-011 SHALL have port commit_trap input 1: retired instruction trapped.
REQ-012 SHALL have port commit_intr_entry input 1: core entered an interrupt handler this cycle.
REQ-013 SHALL have port rvfi_valid output 1: one trace packet valid.
REQ-014 SHALL have port rvfi_order output 64: packet sequence number.
REQ-015 SHALL have ports rvfi_insn output 32, rvfi_trap, rvfi_halt, rvfi_intr output 1 each.
REQ-016 SHALL have ports rvfi_pc_rdata/rvfi_pc_wdata output XLEN each.
REQ-017 SHALL have ports rvfi_rs1_addr/rvfi_rs2_addr/rvfi_rd_addr output 5 each; rvfi_rs1_rdata/rvfi_rs2_rdata/rvfi_rd_wdata output XLEN each.
REQ-018 SHALL have port pc_err output 1 (present only under RVFI_TRACE_PC_CHECK_EN): sticky PC-discontinuity flag.

Function
REQ-019 SHALL register every accepted commit into all rvfi_* outputs with exactly 1-cycle latency; rvfi_valid high for exactly one cycle per accepted commit.
REQ-020 SHALL hold all rvfi_* data outputs at zero in any cycle rvfi_valid is low.
REQ-021 SHALL force rvfi_rd_wdata to 0 whenever commit_rd_addr is 0, regardless of commit_rd_data.
REQ-022 SHALL emit rvfi_order 0 on the first packet after reset and increment by 1 per emitted packet, wrapping 2^64-1 -> 0.
REQ-023 SHALL implement states RUN and HALTED; RUN -> HALTED when an accepted commit has commit_trap=1; HALTED exits only on reset.
REQ-024 SHALL assert rvfi_trap and rvfi_halt together on the trapping packet; in HALTED all commits are dropped, rvfi_valid stays 0, rvfi_order frozen.
REQ-025 SHALL set an intr_pending flag on commit_intr_entry; the next emitted packet after the set cycle carries rvfi_intr=1 and clears the flag.
REQ-026 SHALL, when commit_intr_entry and commit_valid coincide, emit that commit with rvfi_intr=0 and attach intr to the following packet.
REQ-027 SHALL treat repeated commit_intr_entry while pending as a single pending event.

Reset
REQ-028 SHALL, when resetn=0 at a clock edge, clear all outputs to 0, order counter to 0, intr_pending to 0, pc_err to 0, state to RUN, discarding any in-flight packet.
REQ-029 SHALL ignore commit_valid in the reset cycle; the first packet may appear in the cycle after the first clock with resetn=1 and commit_valid=1.

Configuration
REQ-030 SHALL, with RVFI_TRACE_PC_CHECK_EN defined, store last emitted rvfi_pc_wdata and set pc_err when an accepted commit_pc differs from it and the packet is neither the first since reset nor rvfi_intr=1; pc_err sticky until reset.
REQ-031 SHALL, without RVFI_TRACE_PC_CHECK_EN, omit port pc_err and all its state; other behaviour identical.

Structure
REQ-032 SHALL place XLEN default, ILEN=32, order width 64 and the RUN/HALTED state encoding in shared package rvfi_trace_pkg.
REQ-033 SHALL instantiate one sub-module rvfi_order_counter (64-bit, increment-enable, sync active-low clear); everything else inline.

Verification
REQ-034 SHALL test three back-to-back commits after reset -> rvfi_valid 3 consecutive cycles, orders 0,1,2, 1-cycle latency.
REQ-035 SHALL test commit rd_addr=0, rd_data=32'hDEADBEEF -> rvfi_rd_wdata=0, rvfi_rd_addr=0.
REQ-036 SHALL test commit_trap=1 on order 4, then 5 more commits -> packet 4 has rvfi_trap=rvfi_halt=1, no further rvfi_valid.
REQ-037 SHALL test intr_entry coincident with commit at pc 32'h100, next commit pc 32'h10 -> first packet rvfi_intr=0, second rvfi_intr=1, pc_err stays 0.
REQ-038 SHALL test (macro on) commit pc 32'h0 next_pc 32'h4, then commit pc 32'h8 -> pc_err=1 and held until resetn=0 clears it.
REQ-039 SHALL test resetn=0 asserted in cycle commit_valid=1 -> no packet emitted; next packet order 0.

Source files
------------

// File: rtl/rvfi_trace_pkg.sv
// Shared constants and the run/halt state encoding for the RVFI trace generator.
package rvfi_trace_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN         = 32;
  localparam int ORDER_W      = 64;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } trace_state_e;

endpackage

// File: rtl/rvfi_trace_gen_if.sv
// Commit bus from the core and the RVFI packet bus towards the checker.
interface rvfi_trace_gen_if
  import rvfi_trace_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            commit_valid;
  logic [ILEN-1:0] commit_insn;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] commit_next_pc;
  logic [4:0]      commit_rs1_addr;
  logic [4:0]      commit_rs2_addr;
  logic [XLEN-1:0] commit_rs1_data;
  logic [XLEN-1:0] commit_rs2_data;
  logic [4:0]      commit_rd_addr;
  logic [XLEN-1:0] commit_rd_data;
  logic            commit_trap;
  logic            commit_intr_entry;

  logic               rvfi_valid;
  logic [ORDER_W-1:0] rvfi_order;
  logic [ILEN-1:0]    rvfi_insn;
  logic               rvfi_trap;
  logic               rvfi_halt;
  logic               rvfi_intr;
  logic [XLEN-1:0]    rvfi_pc_rdata;
  logic [XLEN-1:0]    rvfi_pc_wdata;
  logic [4:0]         rvfi_rs1_addr;
  logic [4:0]         rvfi_rs2_addr;
  logic [4:0]         rvfi_rd_addr;
  logic [XLEN-1:0]    rvfi_rs1_rdata;
  logic [XLEN-1:0]    rvfi_rs2_rdata;
  logic [XLEN-1:0]    rvfi_rd_wdata;

  // Core side drives commits and observes packets.
  modport master (
    output commit_valid, commit_insn, commit_pc, commit_next_pc,
           commit_rs1_addr, commit_rs2_addr, commit_rs1_data, commit_rs2_data,
           commit_rd_addr, commit_rd_data, commit_trap, commit_intr_entry,
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
           rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr, rvfi_rs2_addr,
           rvfi_rd_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata
  );

  // Trace generator side.
  modport slave (
    input  commit_valid, commit_insn, commit_pc, commit_next_pc,
           commit_rs1_addr, commit_rs2_addr, commit_rs1_data, commit_rs2_data,
           commit_rd_addr, commit_rd_data, commit_trap, commit_intr_entry,
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
           rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr, rvfi_rs2_addr,
           rvfi_rd_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata
  );

endinterface

// File: rtl/rvfi_order_counter.sv
// Free-running 64-bit packet sequence counter with increment enable and sync clear.
module rvfi_order_counter
  import rvfi_trace_pkg::*;
(
  input  logic               clk,
  input  logic               clr_n,
  input  logic               inc,
  output logic [ORDER_W-1:0] count
);

  logic [ORDER_W-1:0] count_q;
  logic [ORDER_W-1:0] count_d;

  // Natural wrap from all-ones back to zero.
  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + ORDER_W'(1);
  end

  // NOTE: clear is sampled on the clock edge; sequential state uses <= so all
  // flops see pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!clr_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/rvfi_trace_gen.sv
// Turns core retirement events into one-cycle-latency RVFI trace packets.
// Optional: define RVFI_TRACE_PC_CHECK_EN to add the sticky pc_err discontinuity flag.
module rvfi_trace_gen
  import rvfi_trace_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  rvfi_trace_gen_if.slave      bus
`ifdef RVFI_TRACE_PC_CHECK_EN
  ,
  output logic                 pc_err
`endif
);

  typedef struct packed {
    logic               valid;
    logic [ORDER_W-1:0] order;
    logic [ILEN-1:0]    insn;
    logic               trap;
    logic               halt;
    logic               intr;
    logic [XLEN-1:0]    pc_rdata;
    logic [XLEN-1:0]    pc_wdata;
    logic [4:0]         rs1_addr;
    logic [4:0]         rs2_addr;
    logic [4:0]         rd_addr;
    logic [XLEN-1:0]    rs1_rdata;
    logic [XLEN-1:0]    rs2_rdata;
    logic [XLEN-1:0]    rd_wdata;
  } pkt_t;

  trace_state_e       state_q, state_d;
  pkt_t               pkt_q, pkt_d;
  logic               intr_pending_q, intr_pending_d;
  logic               accept;
  logic [ORDER_W-1:0] next_order;

  assign accept = bus.commit_valid && (state_q == ST_RUN);

  rvfi_order_counter u_order (
    .clk   (clk),
    .clr_n (resetn),
    .inc   (accept),
    .count (next_order)
  );

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    pkt_d   = '0;
    state_d = state_q;
    // An entry coinciding with a commit belongs to the following packet.
    intr_pending_d = bus.commit_intr_entry | (intr_pending_q & ~accept);
    if (accept) begin
      pkt_d.valid     = 1'b1;
      pkt_d.order     = next_order;
      pkt_d.insn      = bus.commit_insn;
      pkt_d.intr      = intr_pending_q;
      pkt_d.pc_rdata  = bus.commit_pc;
      pkt_d.pc_wdata  = bus.commit_next_pc;
      pkt_d.rs1_addr  = bus.commit_rs1_addr;
      pkt_d.rs2_addr  = bus.commit_rs2_addr;
      pkt_d.rd_addr   = bus.commit_rd_addr;
      pkt_d.rs1_rdata = bus.commit_rs1_data;
      pkt_d.rs2_rdata = bus.commit_rs2_data;
      pkt_d.rd_wdata  = (bus.commit_rd_addr == 5'd0) ? '0 : bus.commit_rd_data;
      if (bus.commit_trap) begin
        pkt_d.trap = 1'b1;
        pkt_d.halt = 1'b1;
        state_d    = ST_HALTED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_RUN;
      pkt_q          <= '0;
      intr_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pkt_q          <= pkt_d;
      intr_pending_q <= intr_pending_d;
    end
  end

`ifdef RVFI_TRACE_PC_CHECK_EN
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic            seen_q, seen_d;
  logic            pc_err_q, pc_err_d;

  // The first packet and interrupt-entry packets legitimately break the PC chain.
  always_comb begin
    last_pc_d = last_pc_q;
    seen_d    = seen_q;
    pc_err_d  = pc_err_q;
    if (accept) begin
      if (seen_q && !intr_pending_q && (bus.commit_pc != last_pc_q)) pc_err_d = 1'b1;
      last_pc_d = bus.commit_next_pc;
      seen_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_pc_q <= '0;
      seen_q    <= 1'b0;
      pc_err_q  <= 1'b0;
    end else begin
      last_pc_q <= last_pc_d;
      seen_q    <= seen_d;
      pc_err_q  <= pc_err_d;
    end
  end

  assign pc_err = pc_err_q;
`endif

  assign bus.rvfi_valid     = pkt_q.valid;
  assign bus.rvfi_order     = pkt_q.order;
  assign bus.rvfi_insn      = pkt_q.insn;
  assign bus.rvfi_trap      = pkt_q.trap;
  assign bus.rvfi_halt      = pkt_q.halt;
  assign bus.rvfi_intr      = pkt_q.intr;
  assign bus.rvfi_pc_rdata  = pkt_q.pc_rdata;
  assign bus.rvfi_pc_wdata  = pkt_q.pc_wdata;
  assign bus.rvfi_rs1_addr  = pkt_q.rs1_addr;
  assign bus.rvfi_rs2_addr  = pkt_q.rs2_addr;
  assign bus.rvfi_rd_addr   = pkt_q.rd_addr;
  assign bus.rvfi_rs1_rdata = pkt_q.rs1_rdata;
  assign bus.rvfi_rs2_rdata = pkt_q.rs2_rdata;
  assign bus.rvfi_rd_wdata  = pkt_q.rd_wdata;

endmodule

// File: tb/tb_rvfi_trace_gen.sv
// Self-checking bench for rvfi_trace_gen: directed scenarios plus random commits
// compared every cycle against a behavioural packet model.
module tb_rvfi_trace_gen;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
  } pkt_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  rvfi_trace_gen_if #(.XLEN(32)) bus ();

`ifdef RVFI_TRACE_PC_CHECK_EN
  logic pc_err;
  rvfi_trace_gen #(.XLEN(32)) dut (.clk(clk), .resetn(resetn), .bus(bus), .pc_err(pc_err));
`else
  rvfi_trace_gen #(.XLEN(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic pkt_t dut_pkt();
    pkt_t p;
    p.valid     = bus.rvfi_valid;
    p.order     = bus.rvfi_order;
    p.insn      = bus.rvfi_insn;
    p.trap      = bus.rvfi_trap;
    p.halt      = bus.rvfi_halt;
    p.intr      = bus.rvfi_intr;
    p.pc_rdata  = bus.rvfi_pc_rdata;
    p.pc_wdata  = bus.rvfi_pc_wdata;
    p.rs1_addr  = bus.rvfi_rs1_addr;
    p.rs2_addr  = bus.rvfi_rs2_addr;
    p.rd_addr   = bus.rvfi_rd_addr;
    p.rs1_rdata = bus.rvfi_rs1_rdata;
    p.rs2_rdata = bus.rvfi_rs2_rdata;
    p.rd_wdata  = bus.rvfi_rd_wdata;
    return p;
  endfunction

  // Behavioural model: what the trace must look like one cycle after each edge.
  pkt_t            exp_pkt = '0;
  bit              model_ready = 1'b0;
  bit              m_halted, m_pending, m_seen, m_pc_err;
  longint unsigned m_order;
  logic [31:0]     m_last_pc;

  always @(posedge clk) begin
    bit acc;
    if (!resetn) begin
      m_halted = 0; m_pending = 0; m_seen = 0; m_pc_err = 0;
      m_order = 0; m_last_pc = '0; exp_pkt = '0;
    end else begin
      acc = bus.commit_valid && !m_halted;
      exp_pkt = '0;
      if (acc) begin
        exp_pkt.valid     = 1'b1;
        exp_pkt.order     = m_order;
        exp_pkt.insn      = bus.commit_insn;
        exp_pkt.intr      = m_pending;
        exp_pkt.trap      = bus.commit_trap;
        exp_pkt.halt      = bus.commit_trap;
        exp_pkt.pc_rdata  = bus.commit_pc;
        exp_pkt.pc_wdata  = bus.commit_next_pc;
        exp_pkt.rs1_addr  = bus.commit_rs1_addr;
        exp_pkt.rs2_addr  = bus.commit_rs2_addr;
        exp_pkt.rd_addr   = bus.commit_rd_addr;
        exp_pkt.rs1_rdata = bus.commit_rs1_data;
        exp_pkt.rs2_rdata = bus.commit_rs2_data;
        exp_pkt.rd_wdata  = (bus.commit_rd_addr == 0) ? 32'd0 : bus.commit_rd_data;
        if (m_seen && !m_pending && bus.commit_pc != m_last_pc) m_pc_err = 1;
        m_last_pc = bus.commit_next_pc;
        m_seen    = 1;
        m_order   = m_order + 1;
        if (bus.commit_trap) m_halted = 1;
      end
      m_pending = bus.commit_intr_entry || (m_pending && !acc);
    end
    model_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check("cycle_pkt", dut_pkt(), exp_pkt);
`ifdef RVFI_TRACE_PC_CHECK_EN
      check("cycle_pc_err", pc_err, m_pc_err);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic v, input logic [31:0] pc, input logic [31:0] npc,
                        input logic [4:0] rd, input logic [31:0] rdd,
                        input logic trap, input logic intr);
    bus.commit_valid      = v;
    bus.commit_insn       = $urandom;
    bus.commit_pc         = pc;
    bus.commit_next_pc    = npc;
    bus.commit_rs1_addr   = 5'($urandom);
    bus.commit_rs2_addr   = 5'($urandom);
    bus.commit_rs1_data   = $urandom;
    bus.commit_rs2_data   = $urandom;
    bus.commit_rd_addr    = rd;
    bus.commit_rd_data    = rdd;
    bus.commit_trap       = trap;
    bus.commit_intr_entry = intr;
  endtask

  task automatic idle();
    commit(1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] cur_pc;
    logic [31:0] pc;
    idle();

    // Reset state
    resetn = 1'b0;
    tick(); tick();
    check("reset_valid", bus.rvfi_valid, 1'b0);
    check("reset_order", bus.rvfi_order, 64'd0);
    resetn = 1'b1;
    tick();
    check("idle_valid", bus.rvfi_valid, 1'b0);

    // Three back-to-back commits, orders 0..2
    commit(1'b1, 32'h0, 32'h4, 5'd1, 32'h11, 1'b0, 1'b0); tick();
    check("b2b0_valid", bus.rvfi_valid, 1'b1);
    check("b2b0_order", bus.rvfi_order, 64'd0);
    commit(1'b1, 32'h4, 32'h8, 5'd2, 32'h22, 1'b0, 1'b0); tick();
    check("b2b1_valid", bus.rvfi_valid, 1'b1);
    check("b2b1_order", bus.rvfi_order, 64'd1);
    commit(1'b1, 32'h8, 32'hC, 5'd3, 32'h33, 1'b0, 1'b0); tick();
    check("b2b2_valid", bus.rvfi_valid, 1'b1);
    check("b2b2_order", bus.rvfi_order, 64'd2);
    check("b2b2_pc", bus.rvfi_pc_rdata, 32'h8);

    // x0 destination never reports written data
    commit(1'b1, 32'hC, 32'h10, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0); tick();
    check("x0_wdata", bus.rvfi_rd_wdata, 32'd0);
    check("x0_addr", bus.rvfi_rd_addr, 5'd0);
    check("x0_order", bus.rvfi_order, 64'd3);

    // Trap on order 4 halts the trace
    commit(1'b1, 32'h10, 32'h14, 5'd4, 32'h44, 1'b1, 1'b0); tick();
    check("trap_valid", bus.rvfi_valid, 1'b1);
    check("trap_order", bus.rvfi_order, 64'd4);
    check("trap_flags", {bus.rvfi_trap, bus.rvfi_halt}, 2'b11);
    for (int i = 0; i < 5; i++) begin
      commit(1'b1, 32'h14 + 4 * i, 32'h18 + 4 * i, 5'd5, 32'h55, 1'b0, 1'b0); tick();
      check("halted_valid", bus.rvfi_valid, 1'b0);
    end

    // Reset coinciding with a commit drops it
    resetn = 1'b0;
    commit(1'b1, 32'h0, 32'h4, 5'd1, 32'h1, 1'b0, 1'b0); tick();
    check("rst_commit_valid", bus.rvfi_valid, 1'b0);
    resetn = 1'b1;

    // Interrupt entry coinciding with a commit attaches to the next packet
    commit(1'b1, 32'h100, 32'h104, 5'd6, 32'h66, 1'b0, 1'b1); tick();
    check("intr0_order", bus.rvfi_order, 64'd0);
    check("intr0_flag", bus.rvfi_intr, 1'b0);
    commit(1'b1, 32'h10, 32'h14, 5'd7, 32'h77, 1'b0, 1'b0); tick();
    check("intr1_order", bus.rvfi_order, 64'd1);
    check("intr1_flag", bus.rvfi_intr, 1'b1);
`ifdef RVFI_TRACE_PC_CHECK_EN
    check("intr_pc_err", pc_err, 1'b0);
`endif
    idle(); tick();

`ifdef RVFI_TRACE_PC_CHECK_EN
    // PC discontinuity is sticky until reset
    resetn = 1'b0; tick(); resetn = 1'b1;
    commit(1'b1, 32'h0, 32'h4, 5'd1, 32'h1, 1'b0, 1'b0); tick();
    check("pcchk_first", pc_err, 1'b0);
    commit(1'b1, 32'h8, 32'hC, 5'd1, 32'h1, 1'b0, 1'b0); tick();
    check("pcchk_set", pc_err, 1'b1);
    idle(); tick(); tick(); tick();
    check("pcchk_sticky", pc_err, 1'b1);
    resetn = 1'b0; tick();
    check("pcchk_clear", pc_err, 1'b0);
    resetn = 1'b1;
`endif

    // Random traffic against the model
    resetn = 1'b0; idle(); tick(); resetn = 1'b1;
    cur_pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      resetn = ($urandom_range(0, 99) >= 3);
      if ($urandom_range(0, 9) < 7) begin
        pc = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFC) : cur_pc;
        cur_pc = pc + 32'd4;
        commit(1'b1, pc, cur_pc,
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
               $urandom, ($urandom_range(0, 49) == 0), ($urandom_range(0, 14) == 0));
      end else begin
        idle();
        bus.commit_intr_entry = ($urandom_range(0, 9) == 0);
      end
      tick();
    end

    resetn = 1'b1; idle(); tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
